// File: rtl/vga_pkg.sv
// Shared VGA pixel-path definitions: colour type, active-area size and common colours.
package vga_pkg;

    localparam int unsigned DEF_COLOR_W = 24;
    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;

    typedef logic [DEF_COLOR_W-1:0] rgb_t;

    localparam rgb_t COLOR_BLACK   = 24'h000000;
    localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
    localparam rgb_t COLOR_RED     = 24'hFF0000;
    localparam rgb_t COLOR_GREEN   = 24'h00FF00;
    localparam rgb_t COLOR_BLUE    = 24'h0000FF;
    localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
    localparam rgb_t KEY_DEFAULT   = COLOR_GREEN;

    typedef enum logic {
        StIdle,
        StRun
    } anim_state_e;

    // Scale shift 3 is not a legal zoom; it folds onto 4x.
    function automatic logic [1:0] clamp_scale(input logic [1:0] sh);
        return (sh == 2'd3) ? 2'd2 : sh;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: divides video frames down and steps the sprite frame index.
module sprite_anim_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES = 4,
    parameter int unsigned IDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             anim_en,
    input  logic [7:0]       anim_div,
    output logic [IDX_W-1:0] frame_idx
);

    anim_state_e      r_state;
    anim_state_e      w_state_next;
    logic [7:0]       r_div_cnt;
    logic [7:0]       w_div_cnt_next;
    logic [IDX_W-1:0] r_frame_idx;
    logic [IDX_W-1:0] w_frame_idx_next;
    logic [7:0]       w_div_last;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_div_cnt   <= 8'd0;
            r_frame_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_div_cnt   <= w_div_cnt_next;
            r_frame_idx <= w_frame_idx_next;
        end
    end

    always_comb begin
        w_state_next     = anim_en ? StRun : StIdle;
        w_div_cnt_next   = r_div_cnt;
        w_frame_idx_next = r_frame_idx;
        w_div_last       = (anim_div == 8'd0) ? 8'd0 : anim_div - 8'd1;
        case (r_state)
            StRun: begin
                if (frame_start) begin
                    // >= so a divider lowered below the running count wraps on the next pulse
                    if (r_div_cnt >= w_div_last) begin
                        w_div_cnt_next   = 8'd0;
                        w_frame_idx_next = (r_frame_idx == IDX_W'(FRAMES - 1)) ?
                                           '0 : r_frame_idx + 1'b1;
                    end else begin
                        w_div_cnt_next = r_div_cnt + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign frame_idx = r_frame_idx;

endmodule

// File: rtl/sprite_layer.sv
// Sprite renderer: hit test and ROM addressing against shadowed origin/scale, then a
// fixed-latency delay line and colour-key transparency stage.
module sprite_layer
    import vga_pkg::*;
#(
    parameter int unsigned W        = 300,
    parameter int unsigned H        = 100,
    parameter int unsigned FRAMES   = 4,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_DEFAULT)
) (
    input  logic               vga_clk,
    input  logic               rst,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               pos_valid,
    input  logic               frame_start,
    input  logic [9:0]         org_x,
    input  logic [9:0]         org_y,
    input  logic [1:0]         scale_sh,
    input  logic               anim_en,
    input  logic [7:0]         anim_div,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               out_valid,
    output logic               out_hit,
    output logic [COLOR_W-1:0] out_data
);

    localparam int unsigned IDX_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned U_W      = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned V_W      = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned FRAME_SZ = W * H;
    localparam int unsigned DLY      = ROM_LAT + 1;

    logic [9:0]         r_org_x;
    logic [9:0]         r_org_y;
    logic [1:0]         r_scale;
    logic [IDX_W-1:0]   w_frame_idx;

    logic [9:0]         w_dx;
    logic [9:0]         w_dy;
    logic [12:0]        w_w_lim;
    logic [12:0]        w_h_lim;
    logic               w_hit;
    logic [U_W-1:0]     w_u;
    logic [V_W-1:0]     w_v;

    logic [U_W-1:0]     r_a_u;
    logic [V_W-1:0]     r_a_v;
    logic [IDX_W-1:0]   r_a_frame;
    logic               r_a_hit;
    logic               r_a_valid;

    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [DLY-1:0]     r_hit_dly;
    logic [DLY-1:0]     r_vld_dly;

    logic               w_opaque;
    logic               r_out_valid;
    logic               r_out_hit;
    logic [COLOR_W-1:0] r_out_data;

    sprite_anim_ctrl #(
        .FRAMES (FRAMES),
        .IDX_W  (IDX_W)
    ) u_anim (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .anim_div    (anim_div),
        .frame_idx   (w_frame_idx)
    );

    // Placement only changes between video frames so a moving sprite never tears.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_org_x <= 10'd0;
            r_org_y <= 10'd0;
            r_scale <= 2'd0;
        end else if (frame_start) begin
            r_org_x <= org_x;
            r_org_y <= org_y;
            r_scale <= clamp_scale(scale_sh);
        end
    end

    always_comb begin
        w_dx    = pos_x - r_org_x;
        w_dy    = pos_y - r_org_y;
        w_w_lim = 13'(W) << r_scale;
        w_h_lim = 13'(H) << r_scale;
        w_hit   = pos_valid && ({3'b000, w_dx} < w_w_lim) && ({3'b000, w_dy} < w_h_lim);
        w_u     = U_W'(w_dx >> r_scale);
        w_v     = V_W'(w_dy >> r_scale);
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_a_u     <= '0;
            r_a_v     <= '0;
            r_a_frame <= '0;
            r_a_hit   <= 1'b0;
            r_a_valid <= 1'b0;
        end else begin
            r_a_u     <= w_u;
            r_a_v     <= w_v;
            r_a_frame <= w_frame_idx;
            r_a_hit   <= w_hit;
            r_a_valid <= pos_valid;
        end
    end

    // Constant multipliers; synthesis reduces these to shift-add trees.
    assign w_addr = ADDR_W'(r_a_frame * FRAME_SZ) + ADDR_W'(r_a_v * W) + ADDR_W'(r_a_u);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_hit_dly  <= '0;
            r_vld_dly  <= '0;
        end else begin
            r_rom_addr <= r_a_hit ? w_addr : '0;
            r_hit_dly  <= {r_hit_dly[DLY-2:0], r_a_hit};
            r_vld_dly  <= {r_vld_dly[DLY-2:0], r_a_valid};
        end
    end

    // Last tap of the delay line lines up with rom_data for the same pixel.
    assign w_opaque = r_hit_dly[DLY-1] && (rom_data != KEY_COLOR);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_vld_dly[DLY-1];
            r_out_hit   <= w_opaque;
            r_out_data  <= w_opaque ? rom_data : '0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign out_valid = r_out_valid;
    assign out_hit   = r_out_hit;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_sprite_layer.sv
// Bench for sprite_layer: two instances (ROM latency 1 and 2) driven in parallel and
// compared against a per-pixel reference model of placement, scaling, animation and keying.
module tb_sprite_layer;

    localparam int unsigned W      = 300;
    localparam int unsigned H      = 100;
    localparam int unsigned FRAMES = 4;
    localparam int unsigned ADDR_W = 17;
    localparam logic [23:0] KEY    = 24'h00FF00;
    localparam int          NCYC   = 4096;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  pos_x, pos_y, org_x, org_y;
    logic        pos_valid, frame_start, anim_en;
    logic [1:0]  scale_sh;
    logic [7:0]  anim_div;

    logic [16:0] rom_addr1, rom_addr2;
    logic [23:0] rom_data1, rom_data2, rom_mid2;
    logic        out_valid1, out_hit1, out_valid2, out_hit2;
    logic [23:0] out_data1, out_data2;

    always #5 vga_clk = ~vga_clk;

    sprite_layer #(.ROM_LAT(1)) u_dut1 (
        .vga_clk(vga_clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
        .frame_start(frame_start), .org_x(org_x), .org_y(org_y), .scale_sh(scale_sh),
        .anim_en(anim_en), .anim_div(anim_div), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .out_valid(out_valid1), .out_hit(out_hit1), .out_data(out_data1)
    );

    sprite_layer #(.ROM_LAT(2)) u_dut2 (
        .vga_clk(vga_clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
        .frame_start(frame_start), .org_x(org_x), .org_y(org_y), .scale_sh(scale_sh),
        .anim_en(anim_en), .anim_div(anim_div), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .out_valid(out_valid2), .out_hit(out_hit2), .out_data(out_data2)
    );

    // Sprite image: every address whose value is 3 mod 7 holds the key colour.
    function automatic logic [23:0] rom_fn(input logic [16:0] a);
        if ((a % 17'd7) == 17'd3) return KEY;
        return 24'h5A0000 ^ {7'd0, a};
    endfunction

    always_ff @(posedge vga_clk) begin
        rom_data1 <= rom_fn(rom_addr1);
        rom_mid2  <= rom_fn(rom_addr2);
        rom_data2 <= rom_mid2;
    end

    logic [16:0] e_addr [NCYC];
    logic        e_vld  [NCYC];
    logic        e_hit  [NCYC];
    logic [23:0] e_data [NCYC];
    bit          kill   [NCYC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_ox, m_oy, m_sc, m_fidx, m_dcnt;
    bit m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void exp_of(input int j, output logic [16:0] ea, output logic ev,
                                   output logic eh, output logic [23:0] ed);
        if (j < 0 || kill[j]) begin
            ea = '0; ev = 1'b0; eh = 1'b0; ed = '0;
        end else begin
            ea = e_addr[j]; ev = e_vld[j]; eh = e_hit[j]; ed = e_data[j];
        end
    endfunction

    task automatic model_reset();
        m_ox = 0; m_oy = 0; m_sc = 0; m_fidx = 0; m_dcnt = 0; m_run = 1'b0;
    endtask

    // One clock: record the expectation for the pixel on the inputs, advance the model
    // across the edge, then check everything that is due.
    task automatic step();
        int dx, dy, a, lim;
        bit h;
        logic [23:0] d;
        logic [16:0] ea;
        logic        ev, eh;
        logic [23:0] ed;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget: cycle %0d exceeds %0d", cyc, NCYC);
            $fatal(1, "bench ran out of expectation storage");
        end
        dx = (int'(pos_x) - m_ox) & 1023;
        dy = (int'(pos_y) - m_oy) & 1023;
        h  = pos_valid && (dx < int'(W << m_sc)) && (dy < int'(H << m_sc));
        a  = h ? (m_fidx * int'(W * H) + (dy >> m_sc) * int'(W) + (dx >> m_sc))
                 % (1 << ADDR_W) : 0;
        d  = rom_fn(17'(a));
        e_addr[cyc] = 17'(a);
        e_vld[cyc]  = pos_valid;
        e_hit[cyc]  = h && (d != KEY);
        e_data[cyc] = (h && (d != KEY)) ? d : 24'h0;
        kill[cyc]   = 1'b0;

        @(posedge vga_clk);
        if (rst) begin
            model_reset();
            for (int j = cyc - 4; j <= cyc; j++) if (j >= 0) kill[j] = 1'b1;
        end else begin
            if (frame_start) begin
                if (m_run) begin
                    lim = (anim_div == 8'd0) ? 0 : int'(anim_div) - 1;
                    if (m_dcnt >= lim) begin
                        m_dcnt = 0;
                        m_fidx = (m_fidx + 1) % FRAMES;
                    end else begin
                        m_dcnt++;
                    end
                end
                m_ox = int'(org_x);
                m_oy = int'(org_y);
                m_sc = (scale_sh == 2'd3) ? 2 : int'(scale_sh);
            end
            m_run = anim_en;
        end
        #1;
        exp_of(cyc - 1, ea, ev, eh, ed);
        check("rom_addr_lat1", 32'(rom_addr1), 32'(ea));
        check("rom_addr_lat2", 32'(rom_addr2), 32'(ea));
        exp_of(cyc - 3, ea, ev, eh, ed);
        check("out_valid_lat1", 32'(out_valid1), 32'(ev));
        check("out_hit_lat1", 32'(out_hit1), 32'(eh));
        check("out_data_lat1", 32'(out_data1), 32'(ed));
        exp_of(cyc - 4, ea, ev, eh, ed);
        check("out_valid_lat2", 32'(out_valid2), 32'(ev));
        check("out_hit_lat2", 32'(out_hit2), 32'(eh));
        check("out_data_lat2", 32'(out_data2), 32'(ed));
        cyc++;
    endtask

    task automatic px(input int x, input int y);
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = 1'b1; frame_start = 1'b0;
        step();
    endtask

    task automatic idle(input int n);
        pos_valid = 1'b0; frame_start = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        pos_valid = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; pos_x = '0; pos_y = '0; pos_valid = 1'b0; frame_start = 1'b0;
        org_x = '0; org_y = '0; scale_sh = '0; anim_en = 1'b0; anim_div = '0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        idle(2);

        // 1x placement
        org_x = 10'd170; org_y = 10'd100; scale_sh = 2'd0;
        pulse();
        px(170, 100); px(469, 199); px(470, 100); px(169, 100); px(300, 200);
        idle(4);

        // 2x and clamped 4x
        org_x = 10'd0; org_y = 10'd0; scale_sh = 2'd1;
        pulse();
        px(3, 5); px(599, 199); px(600, 0); px(0, 200);
        scale_sh = 2'd3;
        pulse();
        px(1023, 399); px(0, 400); px(8, 4);
        idle(4);

        // colour key: addr 3 is transparent, addr 4 is opaque
        scale_sh = 2'd0;
        pulse();
        px(3, 0); px(4, 0);
        idle(4);

        // shadowed origin
        org_x = 10'd170; org_y = 10'd100;
        pulse();
        org_x = 10'd10;
        px(170, 100); px(10, 100);
        idle(2);
        pulse();
        px(10, 100); px(9, 100); px(309, 100);
        idle(4);

        // animation: divide by 2, then hold, then every pulse, then divider lowered
        org_x = 10'd0; org_y = 10'd0; anim_div = 8'd2; anim_en = 1'b1;
        idle(2);
        for (int i = 0; i < 9; i++) begin pulse(); idle(1); px(0, 0); idle(1); end
        anim_en = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) begin pulse(); idle(1); px(0, 0); end
        anim_div = 8'd0; anim_en = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) begin pulse(); px(0, 0); end
        anim_div = 8'd5;
        for (int i = 0; i < 3; i++) begin pulse(); px(1, 0); end
        anim_div = 8'd1;
        pulse(); pulse(); px(1, 0);
        idle(4);

        // reset in the middle of a run of hits
        anim_en = 1'b0; org_x = 10'd20; org_y = 10'd5;
        pulse();
        px(20, 5); px(21, 5); px(22, 5);
        rst = 1'b1;
        px(23, 5);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) px(20 + i, 5 + i);
        idle(5);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            frame_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) begin
                org_x    = 10'($urandom_range(0, 1023));
                org_y    = 10'($urandom_range(0, 1023));
                scale_sh = 2'($urandom_range(0, 3));
                anim_div = 8'($urandom_range(0, 3));
                anim_en  = ($urandom_range(0, 3) != 0);
            end
            pos_valid = ($urandom_range(0, 7) != 0);
            pos_x = 10'(m_ox + int'($urandom_range(0, 1300)) - 100);
            pos_y = 10'(m_oy + int'($urandom_range(0, 500)) - 50);
            step();
        end
        rst = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
